// File: rtl/stream_aligner.sv
// stream_aligner: measures the skew between two sync-marked streams and delays the leading one.
// Define STREAM_ALIGNER_STATS_EN to add the saturating lock_loss_cnt output.
module stream_aligner #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned SKEW_AW    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] din_a,
    input  logic                  sync_a,
    input  logic [DATA_WIDTH-1:0] din_b,
    input  logic                  sync_b,
    input  logic                  rearm,
    output logic [DATA_WIDTH-1:0] dout_a,
    output logic [DATA_WIDTH-1:0] dout_b,
    output logic                  sync_out,
    output logic                  locked,
    output logic [SKEW_AW-1:0]    skew,
    output logic                  a_leads,
    output logic                  err_timeout,
    output logic                  err_misalign
`ifdef STREAM_ALIGNER_STATS_EN
    ,
    output logic [7:0]            lock_loss_cnt
`endif
);
    localparam int unsigned        Depth  = 2 ** SKEW_AW;
    localparam logic [SKEW_AW-1:0] CntMax = {SKEW_AW{1'b1}};
    localparam logic [SKEW_AW-1:0] One    = SKEW_AW'(1);

    typedef enum logic [2:0] {StSearch, StWaitA, StWaitB, StLocked, StError} state_e;

    state_e              state_q, state_d;
    logic [SKEW_AW-1:0]  wr_ptr_q;
    logic [SKEW_AW-1:0]  cnt_q, cnt_d;
    logic [SKEW_AW-1:0]  skew_q, skew_d;
    logic                a_leads_q, a_leads_d;
    logic                err_to_q, err_to_d;
    logic                err_mis_q, err_mis_d;
    logic [DATA_WIDTH-1:0] dout_a_q, dout_a_d, dout_b_q, dout_b_d;
    logic                sync_out_q, sync_out_d;

    logic [DATA_WIDTH:0] buf_a [Depth];
    logic [DATA_WIDTH:0] buf_b [Depth];
    logic [DATA_WIDTH:0] cur_a, cur_b, chk_a, chk_b, out_a, out_b;
    logic [SKEW_AW-1:0]  rd_ptr_q, rd_ptr_d;

    always_ff @(posedge clk) begin
        buf_a[wr_ptr_q] <= {sync_a, din_a};
        buf_b[wr_ptr_q] <= {sync_b, din_b};
    end

    assign cur_a    = {sync_a, din_a};
    assign cur_b    = {sync_b, din_b};
    assign rd_ptr_q = wr_ptr_q - skew_q;
    assign rd_ptr_d = wr_ptr_q - skew_d;

    // Misalign check uses the held skew; the output path uses the skew being latched so the
    // first locked cycle already shows the detection-cycle samples.
    assign chk_a = (a_leads_q && skew_q != '0) ? buf_a[rd_ptr_q] : cur_a;
    assign chk_b = (!a_leads_q && skew_q != '0) ? buf_b[rd_ptr_q] : cur_b;
    assign out_a = (a_leads_d && skew_d != '0) ? buf_a[rd_ptr_d] : cur_a;
    assign out_b = (!a_leads_d && skew_d != '0) ? buf_b[rd_ptr_d] : cur_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StSearch;
            wr_ptr_q   <= '0;
            cnt_q      <= '0;
            skew_q     <= '0;
            a_leads_q  <= 1'b0;
            err_to_q   <= 1'b0;
            err_mis_q  <= 1'b0;
            dout_a_q   <= '0;
            dout_b_q   <= '0;
            sync_out_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_q + One;
            cnt_q      <= cnt_d;
            skew_q     <= skew_d;
            a_leads_q  <= a_leads_d;
            err_to_q   <= err_to_d;
            err_mis_q  <= err_mis_d;
            dout_a_q   <= dout_a_d;
            dout_b_q   <= dout_b_d;
            sync_out_q <= sync_out_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + One;
        skew_d    = skew_q;
        a_leads_d = a_leads_q;
        err_to_d  = err_to_q;
        err_mis_d = err_mis_q;
        if (rearm) begin
            state_d   = StSearch;
            err_to_d  = 1'b0;
            err_mis_d = 1'b0;
        end else begin
            unique case (state_q)
                StSearch: begin
                    if (sync_a && sync_b) begin
                        skew_d    = '0;
                        a_leads_d = 1'b0;
                        state_d   = StLocked;
                    end else if (sync_a) begin
                        state_d = StWaitB;
                        cnt_d   = One;
                    end else if (sync_b) begin
                        state_d = StWaitA;
                        cnt_d   = One;
                    end
                end
                StWaitA: begin
                    if (sync_a) begin
                        skew_d    = cnt_q;
                        a_leads_d = 1'b0;
                        state_d   = StLocked;
                    end else if (sync_b) begin
                        cnt_d = One;
                    end else if (cnt_q == CntMax) begin
                        state_d  = StError;
                        err_to_d = 1'b1;
                    end
                end
                StWaitB: begin
                    if (sync_b) begin
                        skew_d    = cnt_q;
                        a_leads_d = 1'b1;
                        state_d   = StLocked;
                    end else if (sync_a) begin
                        cnt_d = One;
                    end else if (cnt_q == CntMax) begin
                        state_d  = StError;
                        err_to_d = 1'b1;
                    end
                end
                StLocked: begin
                    if (chk_a[DATA_WIDTH] ^ chk_b[DATA_WIDTH]) begin
                        state_d   = StSearch;
                        err_mis_d = 1'b1;
                    end
                end
                StError: state_d = StError;
                default: state_d = StSearch;
            endcase
        end
    end

    always_comb begin
        dout_a_d   = '0;
        dout_b_d   = '0;
        sync_out_d = 1'b0;
        if (state_d == StLocked) begin
            dout_a_d   = out_a[DATA_WIDTH-1:0];
            dout_b_d   = out_b[DATA_WIDTH-1:0];
            sync_out_d = out_a[DATA_WIDTH] & out_b[DATA_WIDTH];
        end
    end

`ifdef STREAM_ALIGNER_STATS_EN
    logic [7:0] loss_q;
    logic       loss_event;

    // Rearm is the only other way out of LOCKED, and it clears the counter anyway.
    assign loss_event = (state_q == StLocked) && (state_d == StSearch) && !rearm;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            loss_q <= 8'd0;
        end else if (rearm) begin
            loss_q <= 8'd0;
        end else if (loss_event && loss_q != 8'hFF) begin
            loss_q <= loss_q + 8'd1;
        end
    end

    assign lock_loss_cnt = loss_q;
`endif

    assign dout_a       = dout_a_q;
    assign dout_b       = dout_b_q;
    assign sync_out     = sync_out_q;
    assign locked       = (state_q == StLocked);
    assign skew         = skew_q;
    assign a_leads      = a_leads_q;
    assign err_timeout  = err_to_q;
    assign err_misalign = err_mis_q;

endmodule

// File: tb/tb_stream_aligner.sv
// Bench for stream_aligner: directed cases plus randomized sync schedules, checked each cycle
// against a timestamp/history reference model.
module tb_stream_aligner;
    localparam int unsigned DW      = 32;
    localparam int unsigned AW      = 4;
    localparam int          HistLen = 16384;
    localparam int          MaxK    = (2 ** AW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] din_a, din_b;
    logic          sync_a, sync_b, rearm;
    logic [DW-1:0] dout_a, dout_b;
    logic          sync_out, locked, a_leads, err_timeout, err_misalign;
    logic [AW-1:0] skew;
`ifdef STREAM_ALIGNER_STATS_EN
    logic [7:0]    lock_loss_cnt;
`endif

    always #5 clk = ~clk;

    stream_aligner #(
        .DATA_WIDTH(DW),
        .SKEW_AW   (AW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .din_a       (din_a),
        .sync_a      (sync_a),
        .din_b       (din_b),
        .sync_b      (sync_b),
        .rearm       (rearm),
        .dout_a      (dout_a),
        .dout_b      (dout_b),
        .sync_out    (sync_out),
        .locked      (locked),
        .skew        (skew),
        .a_leads     (a_leads),
        .err_timeout (err_timeout),
        .err_misalign(err_misalign)
`ifdef STREAM_ALIGNER_STATS_EN
        ,
        .lock_loss_cnt(lock_loss_cnt)
`endif
    );

    int tests = 0;
    int fails = 0;
    int t     = 0;

    logic [DW-1:0] h_da [HistLen];
    logic [DW-1:0] h_db [HistLen];
    bit            h_sa [HistLen];
    bit            h_sb [HistLen];

    typedef enum {MSearch, MWait, MLocked, MError} mstate_e;
    mstate_e m_state;
    bit      m_lead_a, m_a_leads, m_to, m_mis;
    int      m_t_lead, m_skew, m_loss;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, t, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state   = MSearch;
        m_lead_a  = 1'b0;
        m_a_leads = 1'b0;
        m_to      = 1'b0;
        m_mis     = 1'b0;
        m_t_lead  = 0;
        m_skew    = 0;
        m_loss    = 0;
    endtask

    task automatic model_step(input bit sa, input bit sb, input bit rr);
        int k, da, db;
        bit lag, ld;
        if (rr) begin
            m_state = MSearch;
            m_to    = 1'b0;
            m_mis   = 1'b0;
            m_loss  = 0;
            return;
        end
        case (m_state)
            MSearch: begin
                if (sa && sb) begin
                    m_skew    = 0;
                    m_a_leads = 1'b0;
                    m_state   = MLocked;
                end else if (sa || sb) begin
                    m_state  = MWait;
                    m_lead_a = sa;
                    m_t_lead = t;
                end
            end
            MWait: begin
                k   = t - m_t_lead;
                lag = m_lead_a ? sb : sa;
                ld  = m_lead_a ? sa : sb;
                if (lag) begin
                    m_skew    = k;
                    m_a_leads = m_lead_a;
                    m_state   = MLocked;
                end else if (ld) begin
                    m_t_lead = t;
                end else if (k == MaxK) begin
                    m_state = MError;
                    m_to    = 1'b1;
                end
            end
            MLocked: begin
                da = m_a_leads ? m_skew : 0;
                db = m_a_leads ? 0 : m_skew;
                if (h_sa[t-da] != h_sb[t-db]) begin
                    m_mis   = 1'b1;
                    m_state = MSearch;
                    if (m_loss < 255) m_loss++;
                end
            end
            default: ;
        endcase
    endtask

    // One cycle: apply inputs, compare DUT outputs with the model, advance the model.
    task automatic drive(input bit sa, input bit sb, input bit rr);
        int            da, db;
        logic [DW-1:0] ea, eb;
        bit            es;
        din_a   = DW'(t);
        din_b   = DW'(t) ^ 32'hA5A5_0000;
        sync_a  = sa;
        sync_b  = sb;
        rearm   = rr;
        h_da[t] = din_a;
        h_db[t] = din_b;
        h_sa[t] = sa;
        h_sb[t] = sb;
        da = m_a_leads ? m_skew : 0;
        db = m_a_leads ? 0 : m_skew;
        ea = '0;
        eb = '0;
        es = 1'b0;
        if (m_state == MLocked) begin
            ea = h_da[t-1-da];
            eb = h_db[t-1-db];
            es = h_sa[t-1-da] & h_sb[t-1-db];
        end
        check("locked", locked, (m_state == MLocked));
        check("dout_a", dout_a, ea);
        check("dout_b", dout_b, eb);
        check("sync_out", sync_out, es);
        check("skew", skew, m_skew);
        check("a_leads", a_leads, m_a_leads);
        check("err_timeout", err_timeout, m_to);
        check("err_misalign", err_misalign, m_mis);
`ifdef STREAM_ALIGNER_STATS_EN
        check("lock_loss_cnt", lock_loss_cnt, m_loss);
`endif
        model_step(sa, sb, rr);
        t++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic pair(input bit lead_a, input int k);
        if (k == 0) begin
            drive(1'b1, 1'b1, 1'b0);
        end else begin
            drive(lead_a, !lead_a, 1'b0);
            idle(k - 1);
            drive(!lead_a, lead_a, 1'b0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_locked"}, locked, 0);
        check({tag, "_dout_a"}, dout_a, 0);
        check({tag, "_dout_b"}, dout_b, 0);
        check({tag, "_sync_out"}, sync_out, 0);
        check({tag, "_skew"}, skew, 0);
        check({tag, "_a_leads"}, a_leads, 0);
        check({tag, "_err_to"}, err_timeout, 0);
        check({tag, "_err_mis"}, err_misalign, 0);
`ifdef STREAM_ALIGNER_STATS_EN
        check({tag, "_loss"}, lock_loss_cnt, 0);
`endif
    endtask

    bit ra [256];
    bit rb [256];

    initial begin
        int t0;
        rst_n  = 1'b0;
        din_a  = '0;
        din_b  = '0;
        sync_a = 1'b0;
        sync_b = 1'b0;
        rearm  = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;

        // Equal sync at cycle 10.
        idle(10);
        drive(1'b1, 1'b1, 1'b0);
        check("eq_locked", locked, 1);
        check("eq_sync_out", sync_out, 1);
        check("eq_skew", skew, 0);
        check("eq_dout_a", dout_a, 10);
        drive(1'b0, 1'b0, 1'b1);
        idle(3);

        // A leads by 5, then periodic syncs 64 apart.
        t0 = t;
        pair(1'b1, 5);
        check("a5_locked", locked, 1);
        check("a5_skew", skew, 5);
        check("a5_a_leads", a_leads, 1);
        check("a5_dout_a", dout_a, h_da[t0]);
        check("a5_dout_b", dout_b, h_db[t0+5]);
        for (int r = 0; r < 3; r++) begin
            idle(64 - 6);
            pair(1'b1, 5);
            check("a5_periodic_sync", sync_out, 1);
            check("a5_periodic_locked", locked, 1);
        end
        drive(1'b0, 1'b0, 1'b1);
        idle(3);

        // B leads by 3.
        pair(1'b0, 3);
        check("b3_locked", locked, 1);
        check("b3_skew", skew, 3);
        check("b3_a_leads", a_leads, 0);
        drive(1'b0, 1'b0, 1'b1);
        idle(3);

        // Timeout: the lagging sync never arrives.
        drive(1'b1, 1'b0, 1'b0);
        idle(14);
        check("to_not_yet", err_timeout, 0);
        idle(1);
        check("to_set", err_timeout, 1);
        idle(4);
        drive(1'b0, 1'b0, 1'b1);
        check("to_cleared", err_timeout, 0);
        idle(3);

        // Largest correctable skew.
        pair(1'b0, MaxK);
        check("max_locked", locked, 1);
        check("max_skew", skew, MaxK);
        drive(1'b0, 1'b0, 1'b1);
        idle(3);

        // Misalign: the next B sync arrives one cycle early.
        pair(1'b1, 5);
        idle(40);
        drive(1'b1, 1'b0, 1'b0);
        idle(3);
        drive(1'b0, 1'b1, 1'b0);
        check("mis_set", err_misalign, 1);
        check("mis_unlocked", locked, 0);
        check("mis_skew_held", skew, 5);
`ifdef STREAM_ALIGNER_STATS_EN
        check("mis_loss", lock_loss_cnt, 1);
`endif

        // Reset in WAIT_B at cnt=3, then a fresh lock.
        drive(1'b1, 1'b0, 1'b0);
        idle(2);
        sync_a = 1'b0;
        sync_b = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        t += 3;
        idle(2);
        pair(1'b1, 7);
        check("post_reset_locked", locked, 1);
        check("post_reset_skew", skew, 7);
        drive(1'b0, 1'b0, 1'b1);

        // Randomized schedules: random skew/leader, occasional jitter, skew 16 forces timeout.
        for (int it = 0; it < 40; it++) begin
            int k, per, win;
            bit la;
            k   = $urandom_range(0, 16);
            la  = 1'($urandom_range(0, 1));
            per = $urandom_range(24, 44);
            for (int c = 0; c < 256; c++) begin
                ra[c] = 1'b0;
                rb[c] = 1'b0;
            end
            for (int r = 0; r < 3; r++) begin
                int base, lag;
                base = r * per;
                lag  = base + k;
                if (r > 0 && k >= 2 && $urandom_range(0, 5) == 0)
                    lag = ($urandom_range(0, 1) != 0) ? lag + 1 : lag - 1;
                if (la) begin
                    ra[base] = 1'b1;
                    rb[lag]  = 1'b1;
                end else begin
                    rb[base] = 1'b1;
                    ra[lag]  = 1'b1;
                end
            end
            win = 3 * per + 20;
            for (int c = 0; c < win; c++) drive(ra[c], rb[c], (c == win - 1));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
